ring_code_monitor: RTL and testbench
====================================

Name: ring_code_monitor

Overview:
- Receiving-end checker for the one-hot ring counter bus. Samples an N-bit ring code each cycle it is valid and decodes it to a binary index.
- Verifies that successive samples advance by exactly one position, rotate-left (bit i to bit i+1 mod N). Locks after a run of good steps and counts full rotations.
- Flags a sticky error on any sequencing fault. Sits beside or downstream of a ring counter as a liveness/integrity monitor.

Parameters:
- N, 4, ring width; must be ≥ 2.
- LOCK_CNT, 2, consecutive correct steps needed to go from SYNC to LOCKED; ≥ 1.
- CNT_W, 8, width of the rotation counter.
- IW (localparam), $clog2(N), index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- in_valid  in  1  ring_in is sampled this cycle.
- ring_in  in  N  ring code under test.
- err_clr  in  1  single-cycle pulse that clears the error and restarts the hunt.
- idx  out  IW  registered binary index of the last legal one-hot sample.
- idx_valid  out  1  pulses 1 cycle after an in_valid sample that is legal one-hot.
- locked  out  1  high while the FSM is in LOCKED.
- err  out  1  sticky fault flag.
- rot_count  out  CNT_W  completed rotations counted while LOCKED.

Behaviour:
- Reset (rst=0 at clk edge): idx=0, idx_valid=0, locked=0, err=0, rot_count=0, FSM=HUNT, good_cnt=0, ref_idx=0. Reset mid-operation takes effect at that edge and overrides everything.
- Legal sample: exactly one bit of ring_in set. Decode is combinational; idx and idx_valid are registered, so latency is 1 cycle. idx holds its value when there is no legal sample.
- Expected next index: exp = (ref_idx + 1) mod N, where ref_idx is the last accepted index. Wrap means ref_idx = N-1 and the new index = 0.
- in_valid=0: no state, counter or ref change; idx_valid=0.
- HUNT:
  - Legal sample: ref_idx ← index, good_cnt ← 0, go to SYNC.
  - Illegal sample: stay in HUNT.
- SYNC:
  - Legal sample with index == exp: good_cnt++, ref updated. When good_cnt reaches LOCK_CNT, go to LOCKED (locked=1 the next cycle).
  - Legal sample with index != exp: ref ← index, good_cnt ← 0, stay in SYNC.
  - Illegal sample: go to HUNT.
  - err is never set in SYNC.
- LOCKED:
  - Legal sample with index == exp: stay; on a wrap, rot_count ← rot_count + 1 (modulo 2^CNT_W, wraps silently).
  - Any other sample (illegal, or index != exp): go to FAULT, err ← 1, locked ← 0 the next cycle.
- FAULT:
  - Samples are ignored; idx_valid stays 0 and idx holds.
  - err_clr=1: err ← 0, go to HUNT.
  - err_clr together with in_valid in the same cycle: the clear wins and the sample is discarded.
  - err_clr in any state other than FAULT: no effect.
- rot_count is cleared only by reset.

Optional Feature:
- RING_MON_AUTORECOVER_EN defined: in FAULT, a legal sample moves the FSM to SYNC (ref ← index, good_cnt ← 0) without waiting for err_clr. err stays sticky until err_clr, which still clears err in any state.
- Undefined: behaviour exactly as above; FAULT leaves only on err_clr or reset.

Decomposition:
- Package ring_pkg: FSM state enum (HUNT, SYNC, LOCKED, FAULT) and a constant for the rotation direction, rotate-left.
- Sub-module onehot_decode: combinational N→IW index plus a legal flag. This keeps the decode reusable by other ring-bus blocks.

Test Plan (N=4, LOCK_CNT=2, CNT_W=8):
1. Hold rst=0 for 2 cycles, then release → all outputs 0; idle in_valid=0 for 5 cycles → no change.
2. Feed 0001, 0010, 0100 on consecutive cycles → idx 0, 1, 2, each with idx_valid pulsing 1 cycle later; locked=1 one cycle after the 0100 sample.
3. Continue with 1000, 0001, 0010, 0100, 1000, 0001 → rot_count=1 after the first 0001 and 2 after the second; err=0 throughout.
4. While LOCKED after 0001, feed 0100 → err=1, locked=0. Then feed 0010 → idx and idx_valid unchanged. Pulse err_clr together with in_valid=1 → err=0, FSM=HUNT, sample dropped.
5. In SYNC after 0001, feed 0011 → FSM=HUNT, idx_valid=0, idx stays 0. Feed 0100, 1000, 0001 → locked=1.
6. Assert rst=0 while LOCKED with rot_count=5 → next edge: rot_count=0, locked=0, FSM=HUNT. With RING_MON_AUTORECOVER_EN defined, a fault followed by 0010 → FSM=SYNC while err stays 1.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types for the ring-code monitor: FSM state encoding and rotation direction.
package ring_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } ring_state_e;

    // The ring advances bit i -> bit i+1 (mod N).
    localparam bit ROT_LEFT = 1'b1;

endpackage

// File: rtl/onehot_decode.sv
// Combinational one-hot to binary decoder with a legality flag (exactly one bit set).
module onehot_decode #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_code,
    output logic [IW-1:0] o_idx,
    output logic          o_legal
);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_code[i]) begin
                o_idx = o_idx | IW'(i);
            end
        end
        o_legal = (i_code != '0) && ((i_code & (i_code - N'(1))) == '0);
    end

endmodule

// File: rtl/ring_code_monitor.sv
// One-hot ring bus integrity monitor: HUNT for a legal code, SYNC on good steps, LOCKED counts rotations, FAULT is sticky.
// Define RING_MON_AUTORECOVER_EN to let a legal sample pull FAULT back into SYNC while err stays set until err_clr.
module ring_code_monitor
    import ring_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int LOCK_CNT = 2,
    parameter  int CNT_W    = 8,
    localparam int IW       = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     ring_in,
    input  logic             err_clr,
    output logic [IW-1:0]    idx,
    output logic             idx_valid,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] rot_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    ring_state_e      r_state, w_state_nx;
    logic [IW-1:0]    r_ref, w_ref_nx;
    logic [GW-1:0]    r_gc, w_gc_nx;
    logic [IW-1:0]    r_idx, w_idx_nx;
    logic             r_iv, w_iv_nx;
    logic             r_err, w_err_nx;
    logic [CNT_W-1:0] r_rot, w_rot_nx;

    logic [IW-1:0]    w_dec;
    logic             w_legal;
    logic [IW-1:0]    w_exp;
    logic             w_wrap;
    logic             w_take;
    logic             w_step_ok;

    onehot_decode #(.N(N)) u_dec (
        .i_code  (ring_in),
        .o_idx   (w_dec),
        .o_legal (w_legal)
    );

    always_comb begin
        if (ROT_LEFT) begin
            w_wrap = (r_ref == IW'(N - 1));
            w_exp  = w_wrap ? '0 : r_ref + IW'(1);
        end else begin
            w_wrap = (r_ref == '0);
            w_exp  = w_wrap ? IW'(N - 1) : r_ref - IW'(1);
        end
    end

    assign w_take    = in_valid && w_legal;
    assign w_step_ok = w_take && (w_dec == w_exp);

    always_comb begin
        w_state_nx = r_state;
        w_ref_nx   = r_ref;
        w_gc_nx    = r_gc;
        w_idx_nx   = r_idx;
        w_iv_nx    = 1'b0;
        w_err_nx   = r_err;
        w_rot_nx   = r_rot;

`ifdef RING_MON_AUTORECOVER_EN
        if (err_clr) begin
            w_err_nx = 1'b0;
        end
`endif

        if (r_state != ST_FAULT && w_take) begin
            w_idx_nx = w_dec;
            w_iv_nx  = 1'b1;
        end

        case (r_state)
            ST_HUNT: begin
                if (w_take) begin
                    w_ref_nx   = w_dec;
                    w_gc_nx    = '0;
                    w_state_nx = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (in_valid) begin
                    if (!w_legal) begin
                        w_state_nx = ST_HUNT;
                    end else if (w_step_ok) begin
                        w_ref_nx = w_dec;
                        w_gc_nx  = r_gc + GW'(1);
                        if (r_gc == GW'(LOCK_CNT - 1)) begin
                            w_state_nx = ST_LOCKED;
                        end
                    end else begin
                        w_ref_nx = w_dec;
                        w_gc_nx  = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (in_valid) begin
                    if (w_step_ok) begin
                        w_ref_nx = w_dec;
                        if (w_wrap) begin
                            w_rot_nx = r_rot + CNT_W'(1);
                        end
                    end else begin
                        w_state_nx = ST_FAULT;
                        w_err_nx   = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                // The clear takes priority; any sample arriving with it is dropped.
                if (err_clr) begin
                    w_err_nx   = 1'b0;
                    w_state_nx = ST_HUNT;
                end
`ifdef RING_MON_AUTORECOVER_EN
                else if (w_take) begin
                    w_ref_nx   = w_dec;
                    w_gc_nx    = '0;
                    w_idx_nx   = w_dec;
                    w_iv_nx    = 1'b1;
                    w_state_nx = ST_SYNC;
                end
`endif
            end
            default: w_state_nx = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_HUNT;
            r_ref   <= '0;
            r_gc    <= '0;
            r_idx   <= '0;
            r_iv    <= 1'b0;
            r_err   <= 1'b0;
            r_rot   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ref   <= w_ref_nx;
            r_gc    <= w_gc_nx;
            r_idx   <= w_idx_nx;
            r_iv    <= w_iv_nx;
            r_err   <= w_err_nx;
            r_rot   <= w_rot_nx;
        end
    end

    assign idx       = r_idx;
    assign idx_valid = r_iv;
    assign locked    = (r_state == ST_LOCKED);
    assign err       = r_err;
    assign rot_count = r_rot;

endmodule

// File: tb/tb_ring_code_monitor.sv
// Directed-vector bench for ring_code_monitor (N=4, LOCK_CNT=2, CNT_W=8).
module tb_ring_code_monitor;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] ring_in;
    logic       err_clr;
    logic [1:0] idx;
    logic       idx_valid;
    logic       locked;
    logic       err;
    logic [7:0] rot_count;

    ring_code_monitor #(.N(N), .LOCK_CNT(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .ring_in   (ring_in),
        .err_clr   (err_clr),
        .idx       (idx),
        .idx_valid (idx_valid),
        .locked    (locked),
        .err       (err),
        .rot_count (rot_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       v;
        logic [3:0] ring;
        logic       clr;
        logic [1:0] e_idx;
        logic       e_iv;
        logic       e_lk;
        logic       e_err;
        logic [7:0] e_rot;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic rst_n, logic v, logic [3:0] ring, logic clr,
                                logic [1:0] e_idx, logic e_iv, logic e_lk, logic e_err,
                                logic [7:0] e_rot);
        vec_t t;
        t.rst_n = rst_n; t.v = v; t.ring = ring; t.clr = clr;
        t.e_idx = e_idx; t.e_iv = e_iv; t.e_lk = e_lk; t.e_err = e_err; t.e_rot = e_rot;
        return t;
    endfunction

    function automatic void add(logic rst_n, logic v, logic [3:0] ring, logic clr,
                                logic [1:0] e_idx, logic e_iv, logic e_lk, logic e_err,
                                logic [7:0] e_rot);
        tbl.push_back(mk(rst_n, v, ring, clr, e_idx, e_iv, e_lk, e_err, e_rot));
    endfunction

    task automatic apply(input vec_t t, input string tag);
        rst      = t.rst_n;
        in_valid = t.v;
        ring_in  = t.ring;
        err_clr  = t.clr;
        @(posedge clk);
        #1;
        n_vec++;
        if (idx !== t.e_idx || idx_valid !== t.e_iv || locked !== t.e_lk ||
            err !== t.e_err || rot_count !== t.e_rot) begin
            n_bad++;
            $display("FAIL %s: got idx=%0d iv=%b lk=%b err=%b rot=%0d, want idx=%0d iv=%b lk=%b err=%b rot=%0d",
                     tag, idx, idx_valid, locked, err, rot_count,
                     t.e_idx, t.e_iv, t.e_lk, t.e_err, t.e_rot);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; ring_in = '0; err_clr = 1'b0;

        // reset and idle (garbage on the bus while invalid)
        add(0,0,4'b0000,0, 0,0,0,0,0);
        add(0,0,4'b0000,0, 0,0,0,0,0);
        for (int i = 0; i < 5; i++) add(1,0,4'b1111,0, 0,0,0,0,0);
        // acquire lock
        add(1,1,4'b0001,0, 0,1,0,0,0);
        add(1,1,4'b0010,0, 1,1,0,0,0);
        add(1,1,4'b0100,0, 2,1,1,0,0);
`ifndef RING_MON_AUTORECOVER_EN
        // two full rotations
        add(1,1,4'b1000,0, 3,1,1,0,0);
        add(1,1,4'b0001,0, 0,1,1,0,1);
        add(1,1,4'b0010,0, 1,1,1,0,1);
        add(1,1,4'b0100,0, 2,1,1,0,1);
        add(1,1,4'b1000,0, 3,1,1,0,1);
        add(1,1,4'b0001,0, 0,1,1,0,2);
        add(1,0,4'b1111,0, 0,0,1,0,2);
        // skip fault, ignored sample, clear-with-sample drops it
        add(1,1,4'b0100,0, 2,1,0,1,2);
        add(1,1,4'b0010,0, 2,0,0,1,2);
        add(1,1,4'b0010,1, 2,0,0,0,2);
        // back in HUNT: two steps must not lock yet
        add(1,1,4'b0100,0, 2,1,0,0,2);
        add(1,1,4'b1000,0, 3,1,0,0,2);
        add(1,1,4'b0000,0, 3,0,0,0,2);
        // illegal in SYNC returns to HUNT, then relock through a wrap (no count in SYNC)
        add(1,1,4'b0001,0, 0,1,0,0,2);
        add(1,1,4'b0011,0, 0,0,0,0,2);
        add(1,1,4'b0100,0, 2,1,0,0,2);
        add(1,1,4'b1000,0, 3,1,0,0,2);
        add(1,1,4'b0001,0, 0,1,1,0,2);
        for (int k = 0; k < 3; k++) begin
            add(1,1,4'b0010,0, 1,1,1,0,8'(2+k));
            add(1,1,4'b0100,0, 2,1,1,0,8'(2+k));
            add(1,1,4'b1000,0, 3,1,1,0,8'(2+k));
            add(1,1,4'b0001,0, 0,1,1,0,8'(3+k));
        end
        // err_clr outside FAULT has no effect; reset overrides a valid sample
        add(1,0,4'b0000,1, 0,0,1,0,5);
        add(0,1,4'b0010,0, 0,0,0,0,0);
        // out-of-order step in SYNC restarts the good-step count
        add(1,1,4'b0001,0, 0,1,0,0,0);
        add(1,1,4'b0010,0, 1,1,0,0,0);
        add(1,1,4'b1000,0, 3,1,0,0,0);
        add(1,1,4'b0001,0, 0,1,0,0,0);
        add(1,1,4'b0010,0, 1,1,1,0,0);
        // illegal code in LOCKED faults; clear; illegal in HUNT stays
        add(1,1,4'b0000,0, 1,0,0,1,0);
        add(1,0,4'b0000,1, 1,0,0,0,0);
        add(1,1,4'b0110,0, 1,0,0,0,0);
        add(1,1,4'b0010,0, 1,1,0,0,0);
`else
        // auto-recovery: legal sample in FAULT resyncs, err held until cleared
        add(1,1,4'b0100,0, 2,1,0,1,0);
        add(1,1,4'b0010,0, 1,1,0,1,0);
        add(1,1,4'b0100,0, 2,1,0,1,0);
        add(1,1,4'b1000,0, 3,1,1,1,0);
        add(1,0,4'b0000,1, 3,0,1,0,0);
        add(1,1,4'b0000,0, 3,0,0,1,0);
        add(1,1,4'b0001,1, 3,0,0,0,0);
        add(1,1,4'b0010,0, 1,1,0,0,0);
`endif

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // rotation counter wraps modulo 2^CNT_W
        apply(mk(0,0,4'b0000,0, 0,0,0,0,0), "wrap_rst");
        apply(mk(1,1,4'b0001,0, 0,1,0,0,0), "wrap_l0");
        apply(mk(1,1,4'b0010,0, 1,1,0,0,0), "wrap_l1");
        apply(mk(1,1,4'b0100,0, 2,1,1,0,0), "wrap_l2");
        for (int k = 0; k < 256; k++) begin
            apply(mk(1,1,4'b1000,0, 3,1,1,0,8'(k)), $sformatf("wrap_a%0d", k));
            apply(mk(1,1,4'b0001,0, 0,1,1,0,8'(k+1)), $sformatf("wrap_b%0d", k));
            apply(mk(1,1,4'b0010,0, 1,1,1,0,8'(k+1)), $sformatf("wrap_c%0d", k));
            apply(mk(1,1,4'b0100,0, 2,1,1,0,8'(k+1)), $sformatf("wrap_d%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
